fifo_stream: RTL

Parametrised stream FIFO, the successor to the basic block-RAM FIFO. It adds the following:
- First-word-fall-through read side, so `rdDataOut` is valid whenever `rdValidOut=1`.
- Occupancy count output.
- Programmable almost-full and almost-empty flags.
- Synchronous flush.
- Sticky overflow flag.

It sits between accelerator pipeline stages and between the bus interface and compute lanes. Both sides use valid/ready handshakes with full one-word-per-cycle throughput.

---
 rtl/fifo_stream_pkg.sv | 13 +
 rtl/fifo_stream_sdp_ram.sv | 28 ++
 rtl/fifo_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the stream FIFO: the output-buffer size and its
// occupancy arithmetic.
package fifo_stream_pkg;

    localparam int unsigned BUF_ENTRIES = 2;

    typedef logic [1:0] buf_cnt_t;

    function automatic buf_cnt_t buf_cnt_next(buf_cnt_t cnt, logic push, logic pop);
        return cnt + buf_cnt_t'(push) - buf_cnt_t'(pop);
    endfunction

endpackage

// File: rtl/fifo_stream_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read, no reset on the array
// so it maps onto block RAM.
module sdp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_stream.sv
// First-word-fall-through stream FIFO: block RAM plus a 2-entry prefetch buffer,
// with occupancy count, registered almost-full/almost-empty/ready flags and sticky overflow.
module fifo_stream
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned FIFO_SKID  = 0,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                                 clkIn,
    input  logic                                 rstIn,
    input  logic                                 flushIn,
    input  logic [DATA_WIDTH-1:0]                wrDataIn,
    input  logic                                 wrValidIn,
    output logic                                 wrReadyOut,
    output logic [DATA_WIDTH-1:0]                rdDataOut,
    output logic                                 rdValidOut,
    input  logic                                 rdReadyIn,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      countOut,
    output logic                                 almostFullOut,
    output logic                                 almostEmptyOut,
    output logic                                 overflowOut
);

    localparam int unsigned ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_FULL  = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_READY = COUNT_WIDTH'(FIFO_DEPTH - FIFO_SKID);
    localparam logic [COUNT_WIDTH-1:0] CNT_AF    = COUNT_WIDTH'(AF_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] CNT_AE    = COUNT_WIDTH'(AE_LEVEL);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_stream: FIFO_DEPTH must be a power of two >= 4");
    end
    if (FIFO_SKID >= FIFO_DEPTH) begin : g_bad_skid
        $error("fifo_stream: FIFO_SKID must be below FIFO_DEPTH");
    end
    if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH) begin : g_bad_levels
        $error("fifo_stream: need AE_LEVEL < AF_LEVEL <= FIFO_DEPTH");
    end

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] ram_words_q, ram_words_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic                   rd_pend_q;
    buf_cnt_t               buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0]  buf0_q, buf1_q, buf0_d, buf1_d;
    logic                   wr_ready_q, af_q, ae_q, ovf_q;
    logic                   full, wr_en, rd_en, ram_rd_en;
    logic [2:0]             buf_occ;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign rdValidOut     = (buf_cnt_q != '0);
    assign rdDataOut      = buf0_q;
    assign countOut       = count_q;
    assign wrReadyOut     = wr_ready_q;
    assign almostFullOut  = af_q;
    assign almostEmptyOut = ae_q;
    assign overflowOut    = ovf_q;

    assign full  = (count_q == CNT_FULL);
    assign rd_en = rdValidOut & rdReadyIn;
    assign wr_en = wrValidIn & (~full | rd_en) & ~flushIn;

    // Buffer slots taken after this edge, counting the RAM read already in flight.
    assign buf_occ   = 3'(buf_cnt_q) + 3'(rd_pend_q) - 3'(rd_en);
    assign ram_rd_en = (ram_words_q != '0) && (buf_occ < 3'(BUF_ENTRIES)) && !flushIn;

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_ram (
        .clk    (clkIn),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q),
        .wr_data(wrDataIn),
        .rd_en  (ram_rd_en),
        .rd_addr(rd_ptr_q),
        .rd_data(ram_rdata)
    );

    always_comb begin
        count_d     = count_q;
        ram_words_d = ram_words_q + COUNT_WIDTH'(wr_en) - COUNT_WIDTH'(ram_rd_en);
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf_cnt_d   = buf_cnt_next(buf_cnt_q, rd_pend_q, rd_en);
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
        if (rd_en) begin
            buf0_d = buf1_q;
        end
        // Returning RAM word lands in the first slot left free after any pop.
        if (rd_pend_q) begin
            if (buf_cnt_q == buf_cnt_t'(rd_en)) begin
                buf0_d = ram_rdata;
            end else begin
                buf1_d = ram_rdata;
            end
        end
        if (flushIn) begin
            count_d     = '0;
            ram_words_d = '0;
            buf0_d      = '0;
            buf1_d      = '0;
            buf_cnt_d   = '0;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            count_q     <= '0;
            ram_words_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            buf_cnt_q   <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            wr_ready_q  <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            ram_words_q <= ram_words_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            wr_ready_q  <= (count_d < CNT_READY);
            af_q        <= (count_d >= CNT_AF);
            ae_q        <= (count_d <= CNT_AE);
            if (flushIn) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                rd_pend_q <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                end
                if (ram_rd_en) begin
                    rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                end
                rd_pend_q <= ram_rd_en;
                if (wrValidIn && full && !rd_en) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

endmodule
